div_unit: RTL

Iterative radix-2 restoring divider for MIPS DIV/DIVU, located in the EX stage beside the ALU. It accepts operands when the EX instruction is a divide and stalls the pipeline while it iterates. It then presents the quotient on LO and the remainder on HI to the same HI/LO write path that the multiply results use. Flush and memory-stage exception handling match the multiplier: a flush kills the operation, and an exception releases the stall.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_if.sv | 30 +++
 rtl/div_abs_neg.sv | 15 +
 rtl/div_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_if.sv
// EX-stage handshake between pipeline control (master) and the divider (slave).
interface div_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] dividend_i;
  logic [WIDTH-1:0] divisor_i;
  logic             stall_i;
  logic             flush_i;
  logic             mem_except_i;
  logic             stall_o;
  logic             done_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] hi_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, stall_i, flush_i, mem_except_i,
    input  stall_o, done_o, lo_o, hi_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, stall_i, flush_i, mem_except_i,
    output stall_o, done_o, lo_o, hi_o
  );

endinterface

// File: rtl/div_abs_neg.sv
// Conditional two's-complement: passes i_val through, or negates it when i_neg.
// Serves both operand magnitude extraction and result sign correction.
module div_abs_neg
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? ((~i_val) + WIDTH'(1)) : i_val;

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU: quotient on LO, remainder on HI.
// Holds EX stalled while iterating; flush aborts, a MEM exception releases the stall.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int ITER  = DIV_ITER
) (
  input logic  clk_i,
  input logic  rst_ni,
  div_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for a divide in EX; start_i requests a stall immediately
  // CALC  | one quotient bit per cycle for ITER cycles
  // DONE  | results valid on lo_o/hi_o; held while stall_i

  localparam int              CW       = $clog2(ITER);
  localparam logic [1:0]      ST_IDLE  = 2'(IDLE);
  localparam logic [1:0]      ST_CALC  = 2'(CALC);
  localparam logic [1:0]      ST_DONE  = 2'(DONE);
  localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic             w_fit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  assign w_dvd_neg  = bus.signed_i & bus.dividend_i[WIDTH-1];
  assign w_dvs_neg  = bus.signed_i & bus.divisor_i[WIDTH-1];
  assign w_div_zero = (bus.divisor_i == '0);

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
    .i_val (bus.dividend_i),
    .i_neg (w_dvd_neg),
    .o_val (w_dvd_abs)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
    .i_val (bus.divisor_i),
    .i_neg (w_dvs_neg),
    .o_val (w_dvs_abs)
  );

  // Magnitudes are unsigned, so |0x8000_0000| needs no special path;
  // the extra trial bit covers a shifted remainder up to 2*divisor-1.
  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_rem_sh - {1'b0, r_dvs};
  assign w_fit     = ~w_trial[WIDTH];
  assign w_rem_nxt = w_fit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fit};

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_lo (
    .i_val (w_quo_nxt),
    .i_neg (r_qneg),
    .o_val (w_lo_fix)
  );

  div_abs_neg #(.WIDTH(WIDTH)) u_fix_hi (
    .i_val (w_rem_nxt),
    .i_neg (r_rneg),
    .o_val (w_hi_fix)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_lo    <= '0;
      r_hi    <= '0;
    end else if (bus.flush_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_i) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= w_dvd_abs;
            r_dvs  <= w_dvs_abs;
            r_qneg <= w_dvd_neg ^ w_dvs_neg;
            r_rneg <= w_dvd_neg;
            if (w_div_zero) begin
              r_lo    <= DIV_BY_ZERO_LO;
              r_hi    <= bus.dividend_i;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_lo    <= w_lo_fix;
            r_hi    <= w_hi_fix;
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // start_i is still the retiring instruction here, so it is ignored.
          if (!bus.stall_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.stall_o = ~bus.mem_except_i &
                       (((r_state == ST_IDLE) & bus.start_i) | (r_state == ST_CALC));
  assign bus.done_o  = (r_state == ST_DONE);
  assign bus.lo_o    = r_lo;
  assign bus.hi_o    = r_hi;

endmodule
